wb_slave_xbar: RTL and testbench

- Parametrised Wishbone classic slave-side decoder/mux for the user project area. Generalises the fixed two-slave address split to NUM_SLAVES windows.
- Adds registered request and response paths, per-slave forwarding, an error responder for unmapped addresses, and a bus-timeout watchdog, so a hung or absent slave cannot stall the management core.
- Sits between the wrapper's Wishbone port and the accelerator slaves (neuromorphic array, matrix multiplier, future blocks).

---
 rtl/wb_xbar_pkg.sv | 38 +++
 rtl/wb_xbar_watchdog.sv | 28 ++
 rtl/wb_slave_xbar.sv | 141 ++++++++++++++
 tb/tb_wb_slave_xbar.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_xbar_pkg.sv
// rtl/wb_xbar_pkg.sv - shared types, defaults and address decoder for the Wishbone slave crossbar
package wb_xbar_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FWD,
        RESP,
        ERR
    } state_t;

    localparam logic [31:0] DEF_ADDR_MASK = 32'hFFFF_F000;
    localparam logic [31:0] DEF_ERR_DATA  = 32'hDEAD_BEEF;
    localparam int          MAX_SLAVES    = 8;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } decode_t;

    // Scans from the top so the lowest matching window is the one left standing.
    function automatic decode_t addr_decode(
        input logic [31:0]              adr,
        input logic [MAX_SLAVES*32-1:0] bases,
        input logic [31:0]              mask,
        input int                       num
    );
        decode_t d;
        d = '0;
        for (int i = MAX_SLAVES - 1; i >= 0; i--) begin
            if (i < num && ((adr & mask) == bases[32*i +: 32])) begin
                d.hit = 1'b1;
                d.idx = 3'(i);
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/wb_xbar_watchdog.sv
// rtl/wb_xbar_watchdog.sv - forward-phase timeout counter for the Wishbone slave crossbar
module wb_xbar_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = en && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wb_slave_xbar.sv
// rtl/wb_slave_xbar.sv - Wishbone classic slave-side decoder/mux with error responder and timeout
module wb_slave_xbar
    import wb_xbar_pkg::*;
#(
    parameter int                       NUM_SLAVES     = 4,
    parameter logic [NUM_SLAVES*32-1:0] BASE_ADDRS     = {32'h3300_0000, 32'h3200_0000,
                                                          32'h3100_0000, 32'h3000_0000},
    parameter logic [31:0]              ADDR_MASK      = DEF_ADDR_MASK,
    parameter int                       TIMEOUT_CYCLES = 255,
    parameter logic [31:0]              ERR_DATA       = DEF_ERR_DATA
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_ni,
    input  logic                     wbs_cyc_i,
    input  logic                     wbs_stb_i,
    input  logic                     wbs_we_i,
    input  logic [3:0]               wbs_sel_i,
    input  logic [31:0]              wbs_adr_i,
    input  logic [31:0]              wbs_dat_i,
    output logic                     wbs_ack_o,
    output logic [31:0]              wbs_dat_o,
    output logic [NUM_SLAVES-1:0]    s_cyc_o,
    output logic [NUM_SLAVES-1:0]    s_stb_o,
    output logic                     s_we_o,
    output logic [3:0]               s_sel_o,
    output logic [31:0]              s_adr_o,
    output logic [31:0]              s_dat_o,
    input  logic [NUM_SLAVES*32-1:0] s_dat_i,
    input  logic [NUM_SLAVES-1:0]    s_ack_i,
    output logic                     err_o,
    output logic [7:0]               err_cnt_o
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam logic [MAX_SLAVES*32-1:0] BASES_EXT = (MAX_SLAVES*32)'(BASE_ADDRS);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q;
    decode_t            dec;
    logic               accept;
    logic               sel_ack;
    logic               wd_expired;
    logic [NUM_SLAVES-1:0] strobe_vec;

    assign dec     = addr_decode(wbs_adr_i, BASES_EXT, ADDR_MASK, NUM_SLAVES);
    // The ack qualifier keeps the just-completed request from being taken twice.
    assign accept  = (state_q == IDLE) && wbs_cyc_i && wbs_stb_i && !wbs_ack_o;
    assign sel_ack = s_ack_i[idx_q];

    assign strobe_vec = (state_q == FWD) ? (NUM_SLAVES'(1) << idx_q) : '0;
    assign s_cyc_o    = strobe_vec;
    assign s_stb_o    = strobe_vec;

    wb_xbar_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_ni),
        .clr    (accept),
        .en     (state_q == FWD),
        .expired(wd_expired)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = dec.hit ? FWD : ERR;
                end
            end
            FWD: begin
                if (!wbs_cyc_i) begin
                    state_d = IDLE;
                end else if (sel_ack) begin
                    state_d = RESP;
                end else if (wd_expired) begin
                    state_d = ERR;
                end
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            idx_q     <= '0;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            s_we_o    <= 1'b0;
            s_sel_o   <= '0;
            s_adr_o   <= '0;
            s_dat_o   <= '0;
            err_o     <= 1'b0;
            err_cnt_o <= '0;
        end else begin
            wbs_ack_o <= 1'b0;
            err_o     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        idx_q   <= dec.idx[IDX_W-1:0];
                        s_we_o  <= wbs_we_i;
                        s_sel_o <= wbs_sel_i;
                        s_adr_o <= wbs_adr_i;
                        s_dat_o <= wbs_dat_i;
                    end
                end
                FWD: begin
                    // Writes leave the read-data register untouched.
                    if (wbs_cyc_i && sel_ack && !s_we_o) begin
                        wbs_dat_o <= s_dat_i[32*idx_q +: 32];
                    end
                end
                RESP: begin
                    wbs_ack_o <= 1'b1;
                end
                ERR: begin
                    wbs_ack_o <= 1'b1;
                    wbs_dat_o <= ERR_DATA;
                    err_o     <= 1'b1;
                    if (err_cnt_o != 8'hFF) begin
                        err_cnt_o <= err_cnt_o + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_slave_xbar.sv
// tb/tb_wb_slave_xbar.sv - directed scoreboard testbench for wb_slave_xbar
module tb_wb_slave_xbar;

    localparam int NS = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cyc, stb, we;
    logic [3:0]      sel;
    logic [31:0]     adr, wdat;
    logic            wbs_ack_o;
    logic [31:0]     wbs_dat_o;
    logic [NS-1:0]   s_cyc_o, s_stb_o;
    logic            s_we_o;
    logic [3:0]      s_sel_o;
    logic [31:0]     s_adr_o, s_dat_o;
    logic [NS*32-1:0] s_dat_i;
    logic [NS-1:0]   s_ack_i;
    logic            err_o;
    logic [7:0]      err_cnt_o;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    wb_slave_xbar #(
        .NUM_SLAVES    (NS),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .wbs_cyc_i(cyc),
        .wbs_stb_i(stb),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(wdat),
        .wbs_ack_o(wbs_ack_o),
        .wbs_dat_o(wbs_dat_o),
        .s_cyc_o  (s_cyc_o),
        .s_stb_o  (s_stb_o),
        .s_we_o   (s_we_o),
        .s_sel_o  (s_sel_o),
        .s_adr_o  (s_adr_o),
        .s_dat_o  (s_dat_o),
        .s_dat_i  (s_dat_i),
        .s_ack_i  (s_ack_i),
        .err_o    (err_o),
        .err_cnt_o(err_cnt_o)
    );

    always #5 clk = ~clk;

    int          ack_delay [NS];
    int          stb_cnt   [NS];
    logic [31:0] rdata     [NS];
    logic [NS-1:0] late_ack;

    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
            stb_cnt[i] <= s_stb_o[i] ? stb_cnt[i] + 1 : 0;
        end
    end

    always_comb begin
        s_ack_i = '0;
        s_dat_i = '0;
        for (int i = 0; i < NS; i++) begin
            s_ack_i[i] = late_ack[i] |
                         (s_stb_o[i] && ack_delay[i] >= 0 && stb_cnt[i] == ack_delay[i]);
            s_dat_i[32*i +: 32] = rdata[i];
        end
    end

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];

    logic [31:0] lat_dat, lat_adr;
    logic [3:0]  lat_sel;
    logic        lat_we;
    int          lat, stb_cyc;

    task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic w,
                        input logic [3:0] s, input int slave,
                        input logic [31:0] exp_data, input logic exp_err,
                        output int latency, output int stb_cycles);
        exp_t e;
        logic got;
        logic [3:0] exp_oh;
        e.data = exp_data;
        e.err  = exp_err;
        sb.push_back(e);
        exp_oh = (slave >= 0) ? 4'(1 << slave) : 4'b0000;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; wdat = d;
        got = 1'b0; latency = 0; stb_cycles = 0;
        for (int n = 1; n <= 200 && !got; n++) begin
            @(negedge clk);
            if (s_stb_o != '0) begin
                if (stb_cycles == 0) begin
                    lat_dat = s_dat_o; lat_adr = s_adr_o; lat_sel = s_sel_o; lat_we = s_we_o;
                end
                stb_cycles++;
                chk("stb_onehot", s_stb_o, exp_oh);
            end
            if (wbs_ack_o) begin
                got = 1'b1;
                latency = n;
                e = sb.pop_front();
                chk("ack_data", wbs_dat_o, e.data);
                chk("err_pulse", err_o, e.err);
            end
        end
        chk("ack_seen", got, 1'b1);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        chk("ack_one_cycle", wbs_ack_o, 1'b0);
        chk("err_one_cycle", err_o, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; wdat = 0;
        late_ack = '0;
        for (int i = 0; i < NS; i++) begin
            ack_delay[i] = 0;
            rdata[i] = 32'h1111_0000 * (i + 1);
        end
        repeat (2) @(negedge clk);
        chk("rst_ack", wbs_ack_o, 1'b0);
        chk("rst_dat", wbs_dat_o, 32'h0);
        chk("rst_stb", s_stb_o, 4'b0);
        chk("rst_cyc", s_cyc_o, 4'b0);
        chk("rst_we", s_we_o, 1'b0);
        chk("rst_sel", s_sel_o, 4'b0);
        chk("rst_adr", s_adr_o, 32'h0);
        chk("rst_sdat", s_dat_o, 32'h0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_errcnt", err_cnt_o, 8'h0);
        rst_n = 1'b1;

        ack_delay[1] = 2; rdata[1] = 32'h1234_5678;
        xfer(32'h3100_0010, 32'h0, 1'b0, 4'hF, 1, 32'h1234_5678, 1'b0, lat, stb_cyc);
        chk("rd_latency", lat, 5);
        chk("rd_stb_cycles", stb_cyc, 3);
        chk("rd_adr", lat_adr, 32'h3100_0010);
        chk("rd_errcnt", err_cnt_o, 8'h0);

        ack_delay[0] = 0;
        xfer(32'h3000_0004, 32'hA5A5_A5A5, 1'b1, 4'b0011, 0, 32'h1234_5678, 1'b0, lat, stb_cyc);
        chk("wr_sdat", lat_dat, 32'hA5A5_A5A5);
        chk("wr_sel", lat_sel, 4'b0011);
        chk("wr_we", lat_we, 1'b1);
        chk("wr_latency", lat, 3);
        chk("wr_errcnt", err_cnt_o, 8'h0);

        xfer(32'h3400_0000, 32'h0, 1'b0, 4'hF, -1, 32'hDEAD_BEEF, 1'b1, lat, stb_cyc);
        chk("unm_latency", lat, 2);
        chk("unm_no_stb", stb_cyc, 0);
        chk("unm_errcnt", err_cnt_o, 8'h1);

        ack_delay[2] = -1;
        xfer(32'h3200_0008, 32'h0, 1'b0, 4'hF, 2, 32'hDEAD_BEEF, 1'b1, lat, stb_cyc);
        chk("to_stb_cycles", stb_cyc, 16);
        chk("to_errcnt", err_cnt_o, 8'h2);
        late_ack[2] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("late_ack_ignored", wbs_ack_o, 1'b0);
            chk("late_ack_no_stb", s_stb_o, 4'b0);
        end
        late_ack[2] = 1'b0;

        ack_delay[0] = -1;
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; adr = 32'h3000_0000;
        repeat (3) @(negedge clk);
        chk("abort_stb_before", s_stb_o, 4'b0001);
        cyc = 0; stb = 0;
        @(negedge clk);
        chk("abort_stb_after", s_stb_o, 4'b0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_ack", wbs_ack_o, 1'b0);
        end
        ack_delay[3] = 1; rdata[3] = 32'hCAFE_F00D;
        xfer(32'h3300_0020, 32'h0, 1'b0, 4'hF, 3, 32'hCAFE_F00D, 1'b0, lat, stb_cyc);
        chk("post_abort_latency", lat, 4);

        for (int i = 0; i < 300; i++) begin
            xfer(32'h3400_0000 | (i << 4), 32'h0, 1'b0, 4'hF, -1, 32'hDEAD_BEEF, 1'b1, lat, stb_cyc);
        end
        chk("errcnt_saturated", err_cnt_o, 8'hFF);

        ack_delay[2] = -1;
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; adr = 32'h3200_0000;
        repeat (3) @(negedge clk);
        chk("rstfwd_stb_before", s_stb_o, 4'b0100);
        #2 rst_n = 1'b0;
        #1;
        chk("rstfwd_stb", s_stb_o, 4'b0);
        chk("rstfwd_ack", wbs_ack_o, 1'b0);
        chk("rstfwd_errcnt", err_cnt_o, 8'h0);
        cyc = 0; stb = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("rstfwd_no_ack", wbs_ack_o, 1'b0);
        end

        ack_delay[1] = 0; rdata[1] = 32'h0BAD_F00D;
        xfer(32'h3100_0000, 32'h0, 1'b0, 4'hF, 1, 32'h0BAD_F00D, 1'b0, lat, stb_cyc);
        chk("post_rst_latency", lat, 3);
        chk("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
